rtg_fault_sched: RTL and testbench

Hardware sequencer for constrained random test generation (CRTG) fault grading on the c880 good/faulty pair.
- Generates candidate vectors from an LFSR and walks the fault list, driving the injection controls of the faulty copy.
- Samples the good-vs-faulty output mismatch, applies fault dropping and the efficiency threshold, and emits kept vectors.
- Stops on the coverage target or on the useless-test limit; replaces the simulator-side generation loop.

---
 rtl/rtg_pkg.sv | 40 ++++
 rtl/rtg_lfsr.sv | 47 ++++
 rtl/rtg_fault_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_rtg_fault_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtg_pkg
// Description : Shared types and constants for the CRTG fault-grading
//               sequencer: FSM state encoding, LFSR tap positions and the
//               default parameter set for the c880 good/faulty pair.
// Revision    : 1.0 - initial release
// ============================================================================
package rtg_pkg;

  // Default parameter set (c880, 980 collapsed faults)
  localparam int DEF_VEC_W      = 60;
  localparam int DEF_NUM_FAULTS = 980;
  localparam int DEF_FIDX_W     = 10;
  localparam int DEF_EF_COUNT   = 3;
  localparam int DEF_UT_LIMIT   = 50;
  localparam int DEF_COV_TARGET = 882;
  localparam int DEF_SETTLE     = 6;

  // Feedback polynomial x^60 + x^59 + 1, expressed as 1-based exponents
  localparam int LFSR_TAP_HI = 60;
  localparam int LFSR_TAP_LO = 59;

  // Saturation ceiling of the 16-bit vector counters
  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  // Sequencer states, explicitly encoded in 3 bits
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_INJ   = 3'd3,
    ST_REM   = 3'd4,
    ST_EVAL  = 3'd5,
    ST_EMIT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage : rtg_pkg
`default_nettype wire

// File: rtl/rtg_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rtg_lfsr
// Description : Fibonacci LFSR producing candidate test vectors. A zero seed
//               is replaced by all-ones so the register never locks up.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               load, seed    - load seed (zero-seed fixup applied)
//               step          - advance one position
//               value         - current register contents
//               next_value    - contents after one step
// Revision    : 1.0 - initial release
// ============================================================================
module rtg_lfsr
  import rtg_pkg::*;
#(
  parameter int WIDTH  = DEF_VEC_W,
  parameter int TAP_HI = LFSR_TAP_HI,
  parameter int TAP_LO = LFSR_TAP_LO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

  logic [WIDTH-1:0] r_lfsr;
  logic             w_feedback;

  assign w_feedback = r_lfsr[TAP_HI-1] ^ r_lfsr[TAP_LO-1];
  assign next_value = {r_lfsr[WIDTH-2:0], w_feedback};
  assign value      = r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '0;
    end else if (load) begin
      r_lfsr <= (seed == '0) ? '1 : seed;
    end else if (step) begin
      r_lfsr <= next_value;
    end
  end

endmodule : rtg_lfsr
`default_nettype wire

// File: rtl/rtg_fault_sched.sv
`default_nettype none
// ============================================================================
// Module      : rtg_fault_sched
// Description : CRTG fault-grading sequencer. Generates LFSR candidates,
//               walks the fault list driving the faulty copy's injection
//               controls, samples good/faulty mismatch, applies fault
//               dropping and the efficiency threshold, and hands kept
//               vectors to a logger. Stops on coverage or useless limit.
// Ports       : clk, rst               - clock, async active-high reset
//               start, lfsr_seed       - session start pulse and seed
//               test_vec               - candidate applied to both circuits
//               fault_idx, inject      - fault selection and injection
//               mismatch               - good/faulty outputs differ
//               acc_valid, acc_ready   - kept-vector handshake
//               busy, done, stop_reason- session status
//               cov_count, kept_count, total_count - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module rtg_fault_sched
  import rtg_pkg::*;
#(
  parameter int VEC_W      = DEF_VEC_W,
  parameter int NUM_FAULTS = DEF_NUM_FAULTS,
  parameter int FIDX_W     = DEF_FIDX_W,
  parameter int EF_COUNT   = DEF_EF_COUNT,
  parameter int UT_LIMIT   = DEF_UT_LIMIT,
  parameter int COV_TARGET = DEF_COV_TARGET,
  parameter int SETTLE     = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VEC_W-1:0]  lfsr_seed,
  output logic [VEC_W-1:0]  test_vec,
  output logic [FIDX_W-1:0] fault_idx,
  output logic              inject,
  input  logic              mismatch,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              done,
  output logic              stop_reason,
  output logic [FIDX_W:0]   cov_count,
  output logic [15:0]       kept_count,
  output logic [15:0]       total_count
);

  localparam int CNT_W = FIDX_W + 1;
  localparam int SET_W = 4;

  localparam logic [FIDX_W-1:0] LAST_IDX    = FIDX_W'(NUM_FAULTS - 1);
  localparam logic [FIDX_W-1:0] IDX_ONE     = FIDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  EF_THRESH   = CNT_W'(EF_COUNT);
  localparam logic [CNT_W-1:0]  COV_GOAL    = CNT_W'(COV_TARGET);
  localparam logic [CNT_W:0]    COV_CEIL    = (CNT_W + 1)'(NUM_FAULTS);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);
  localparam logic [15:0]       UT_MAX      = 16'(UT_LIMIT);
  localparam logic [NUM_FAULTS-1:0] BIT_ONE = NUM_FAULTS'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_FAULTS-1:0] r_at_list;     // faults already detected (dropped)
  logic [NUM_FAULTS-1:0] r_ct_list;     // faults detected by this candidate
  logic [CNT_W-1:0]      r_ct_count;
  logic [15:0]           r_useless;
  logic [SET_W-1:0]      r_settle;

  logic [NUM_FAULTS-1:0] w_at_shift;
  logic                  w_dropped;
  logic                  w_last;
  logic                  w_settle_done;
  logic                  w_keep;
  logic                  w_cov_met;
  logic [15:0]           w_useless_inc;
  logic                  w_useless_hit;
  state_t                w_term_state;
  logic [CNT_W:0]        w_cov_sum;
  logic                  w_idle_like;
  logic                  w_lfsr_load;
  logic [VEC_W-1:0]      w_lfsr_value;
  logic [VEC_W-1:0]      w_lfsr_next;

  // Shift rather than index so the select stays width-clean for any
  // NUM_FAULTS / FIDX_W combination.
  assign w_at_shift    = r_at_list >> fault_idx;
  assign w_dropped     = w_at_shift[0];
  assign w_last        = (fault_idx == LAST_IDX);
  assign w_settle_done = (r_settle == SETTLE_LAST);
  assign w_keep        = (r_ct_count >= EF_THRESH);
  assign w_cov_met     = (cov_count >= COV_GOAL);
  assign w_useless_inc = r_useless + 16'd1;
  assign w_cov_sum     = {1'b0, cov_count} + {1'b0, r_ct_count};
  assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_lfsr_load   = w_idle_like && start;

  // A rejecting EVAL compares the useless count it is about to write.
  assign w_useless_hit = (r_state == ST_EVAL) ? (w_useless_inc == UT_MAX)
                                              : (r_useless == UT_MAX);

  // Terminate-check: coverage wins over the useless limit.
  always_comb begin
    w_term_state = ST_GEN;
    if (w_cov_met || w_useless_hit) begin
      w_term_state = ST_DONE;
    end
  end

  rtg_lfsr #(
    .WIDTH  (VEC_W),
    .TAP_HI (LFSR_TAP_HI),
    .TAP_LO (LFSR_TAP_LO)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (w_lfsr_load),
    .seed       (lfsr_seed),
    .step       (r_state == ST_GEN),
    .value      (w_lfsr_value),
    .next_value (w_lfsr_next)
  );

  // ---------------------------------------------------------------- FSM: state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ----------------------------------------------------------- FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_GEN;
      ST_GEN:           w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!w_dropped)  w_state_nxt = ST_INJ;
        else if (w_last) w_state_nxt = ST_EVAL;
      end
      ST_INJ:           if (w_settle_done) w_state_nxt = ST_REM;
      ST_REM:           w_state_nxt = w_last ? ST_EVAL : ST_CHECK;
      ST_EVAL:          w_state_nxt = w_keep ? ST_EMIT : w_term_state;
      ST_EMIT:          if (acc_ready) w_state_nxt = w_term_state;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- FSM: outputs
  // Decoded straight from the state register so reset drops inject at once.
  always_comb begin
    inject    = (r_state == ST_INJ);
    acc_valid = (r_state == ST_EMIT);
    done      = (r_state == ST_DONE);
    busy      = !w_idle_like;
  end

  // ------------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_vec    <= '0;
      fault_idx   <= '0;
      stop_reason <= 1'b0;
      cov_count   <= '0;
      kept_count  <= '0;
      total_count <= '0;
      r_at_list   <= '0;
      r_ct_list   <= '0;
      r_ct_count  <= '0;
      r_useless   <= '0;
      r_settle    <= '0;
    end else begin
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        stop_reason <= !w_cov_met;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_at_list   <= '0;
            cov_count   <= '0;
            kept_count  <= '0;
            total_count <= '0;
            r_useless   <= '0;
          end
        end
        ST_GEN: begin
          test_vec    <= w_lfsr_next;
          total_count <= (total_count == CNT16_MAX) ? total_count
                                                    : total_count + 16'd1;
          r_ct_list   <= '0;
          r_ct_count  <= '0;
          fault_idx   <= '0;
        end
        ST_CHECK: begin
          r_settle <= '0;
          if (w_dropped && !w_last) begin
            fault_idx <= fault_idx + IDX_ONE;
          end
        end
        ST_INJ: begin
          r_settle <= r_settle + SET_ONE;
          if (w_settle_done && mismatch) begin
            r_ct_list  <= r_ct_list | (BIT_ONE << fault_idx);
            r_ct_count <= r_ct_count + CNT_ONE;
          end
        end
        ST_REM: begin
          if (!w_last) begin
            fault_idx <= fault_idx + IDX_ONE;
          end
        end
        ST_EVAL: begin
          if (w_keep) begin
            r_at_list  <= r_at_list | r_ct_list;
            cov_count  <= (w_cov_sum > COV_CEIL) ? COV_CEIL[CNT_W-1:0]
                                                 : w_cov_sum[CNT_W-1:0];
            kept_count <= (kept_count == CNT16_MAX) ? kept_count
                                                    : kept_count + 16'd1;
            r_useless  <= '0;
          end else begin
            r_useless <= w_useless_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // The LFSR register itself is only observed through test_vec.
  logic w_unused;
  assign w_unused = ^w_lfsr_value;

endmodule : rtg_fault_sched
`default_nettype wire

// File: tb/tb_rtg_fault_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtg_fault_sched
// Description : Directed self-checking bench for rtg_fault_sched using an
//               8-fault list, SETTLE=4, UT_LIMIT=5, COV_TARGET=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtg_fault_sched;

  localparam int VW = 60;
  localparam int SETTLE_TB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] lfsr_seed;
  logic [VW-1:0] test_vec;
  logic [9:0]    fault_idx;
  logic          inject;
  logic          mismatch;
  logic          acc_valid;
  logic          acc_ready;
  logic          busy;
  logic          done;
  logic          stop_reason;
  logic [10:0]   cov_count;
  logic [15:0]   kept_count;
  logic [15:0]   total_count;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  // monitor state
  int         pulses;
  int         acc_rises;
  int         cur_w;
  int         last_w;
  logic [7:0] inj_mask [0:15];
  logic       prev_inj = 1'b0;
  logic       prev_acc = 1'b0;

  rtg_fault_sched #(
    .VEC_W      (VW),
    .NUM_FAULTS (8),
    .FIDX_W     (10),
    .EF_COUNT   (3),
    .UT_LIMIT   (5),
    .COV_TARGET (8),
    .SETTLE     (SETTLE_TB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lfsr_seed   (lfsr_seed),
    .test_vec    (test_vec),
    .fault_idx   (fault_idx),
    .inject      (inject),
    .mismatch    (mismatch),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .busy        (busy),
    .done        (done),
    .stop_reason (stop_reason),
    .cov_count   (cov_count),
    .kept_count  (kept_count),
    .total_count (total_count)
  );

  always #5 clk = ~clk;

  // Fault-response model of the faulty copy
  always_comb begin
    case (mode)
      0:       mismatch = 1'b0;
      1:       mismatch = inject;
      2:       mismatch = inject && (((total_count == 16'd1) && (fault_idx < 10'd4)) ||
                                     ((total_count == 16'd2) && (fault_idx >= 10'd4)));
      default: mismatch = inject && (fault_idx < 10'd2);
    endcase
  end

  always @(negedge clk) begin
    if (start) begin
      pulses = 0; acc_rises = 0; cur_w = 0; last_w = 0;
      for (int i = 0; i < 16; i++) inj_mask[i] = 8'h00;
    end else begin
      if (inject && !prev_inj) pulses++;
      if (inject) begin
        inj_mask[total_count[3:0]][fault_idx[2:0]] = 1'b1;
        cur_w++;
      end else if (prev_inj) begin
        last_w = cur_w;
        cur_w  = 0;
      end
      if (acc_valid && !prev_acc) acc_rises++;
    end
    prev_inj = inject;
    prev_acc = acc_valid;
  end

  function automatic logic [VW-1:0] lfsr_step(input logic [VW-1:0] s);
    return {s[VW-2:0], s[59] ^ s[58]};
  endfunction

  task automatic start_session(input logic [VW-1:0] seed, input int m);
    @(negedge clk); #1;
    mode = m; lfsr_seed = seed; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, n);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lfsr_seed = '0; acc_ready = 1'b1;
    repeat (2) @(negedge clk);
    if ({inject, busy, done, acc_valid, stop_reason} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {inject, busy, done, acc_valid, stop_reason});
    end
    checks++;
    if ({cov_count, kept_count, total_count} !== 43'd0) begin
      errors++; $display("FAIL reset_counts: cov=%0d kept=%0d total=%0d required 0", cov_count, kept_count, total_count);
    end
    checks++;
    if ({test_vec, fault_idx} !== 70'd0) begin
      errors++; $display("FAIL reset_vec: vec=%h idx=%0d required 0", test_vec, fault_idx);
    end
    checks++;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_inject();
    int n = 0;
    start_session(60'h0123_4567_89AB_CDE, 1);
    while (!inject && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (inject !== 1'b1) begin
      errors++; $display("FAIL midrst_reach_inj: inject=%b required 1", inject);
    end
    checks++;
    #1 rst = 1'b1;
    #1;
    if ({inject, busy, done, acc_valid} !== 4'b0) begin
      errors++; $display("FAIL midrst_flags: got %b required 0000", {inject, busy, done, acc_valid});
    end
    checks++;
    if ({cov_count, kept_count, total_count} !== 43'd0) begin
      errors++; $display("FAIL midrst_counts: cov=%0d kept=%0d total=%0d required 0", cov_count, kept_count, total_count);
    end
    checks++;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_detect();
    logic [VW-1:0] seed = 60'h0123_4567_89AB_CDE;
    start_session(seed, 1);
    wait_done("full");
    if (pulses != 8) begin errors++; $display("FAIL full_pulses: got %0d required 8", pulses); end
    checks++;
    if (last_w != SETTLE_TB) begin errors++; $display("FAIL full_inj_width: got %0d required %0d", last_w, SETTLE_TB); end
    checks++;
    if (acc_rises != 1) begin errors++; $display("FAIL full_acc: got %0d required 1", acc_rises); end
    checks++;
    if ({cov_count, kept_count, total_count} !== {11'd8, 16'd1, 16'd1}) begin
      errors++; $display("FAIL full_counts: cov=%0d kept=%0d total=%0d required 8/1/1", cov_count, kept_count, total_count);
    end
    checks++;
    if ({stop_reason, busy} !== 2'b00) begin
      errors++; $display("FAIL full_status: reason=%b busy=%b required 0/0", stop_reason, busy);
    end
    checks++;
    if (test_vec !== lfsr_step(seed)) begin
      errors++; $display("FAIL full_vec: got %h required %h", test_vec, lfsr_step(seed));
    end
    checks++;
  endtask

  task automatic test_useless_limit();
    logic [VW-1:0] exp_v = '1;
    start_session('0, 0);   // zero seed -> all-ones
    wait_done("useless");
    for (int i = 0; i < 5; i++) exp_v = lfsr_step(exp_v);
    if ({kept_count, total_count} !== {16'd0, 16'd5}) begin
      errors++; $display("FAIL useless_counts: kept=%0d total=%0d required 0/5", kept_count, total_count);
    end
    checks++;
    if (pulses != 40) begin errors++; $display("FAIL useless_pulses: got %0d required 40", pulses); end
    checks++;
    if (acc_rises != 0) begin errors++; $display("FAIL useless_acc: got %0d required 0", acc_rises); end
    checks++;
    if (stop_reason !== 1'b1) begin errors++; $display("FAIL useless_reason: got %b required 1", stop_reason); end
    checks++;
    if (test_vec !== exp_v) begin errors++; $display("FAIL useless_vec: got %h required %h", test_vec, exp_v); end
    checks++;
  endtask

  task automatic test_fault_dropping();
    start_session(60'h0F0F_0F0F_0F0F_0F0, 2);
    wait_done("drop");
    if (inj_mask[1] !== 8'hFF) begin errors++; $display("FAIL drop_mask1: got %h required ff", inj_mask[1]); end
    checks++;
    if (inj_mask[2] !== 8'hF0) begin errors++; $display("FAIL drop_mask2: got %h required f0", inj_mask[2]); end
    checks++;
    if (pulses != 12) begin errors++; $display("FAIL drop_pulses: got %0d required 12", pulses); end
    checks++;
    if ({cov_count, kept_count, total_count, stop_reason} !== {11'd8, 16'd2, 16'd2, 1'b0}) begin
      errors++; $display("FAIL drop_counts: cov=%0d kept=%0d total=%0d reason=%b required 8/2/2/0", cov_count, kept_count, total_count, stop_reason);
    end
    checks++;
  endtask

  task automatic test_efficiency_reject();
    start_session(60'h5A5A_5A5A_5A5A_5A5, 3);
    wait_done("eff");
    if ((inj_mask[1] !== 8'hFF) || (inj_mask[5] !== 8'hFF)) begin
      errors++; $display("FAIL eff_masks: c1=%h c5=%h required ff/ff", inj_mask[1], inj_mask[5]);
    end
    checks++;
    if (pulses != 40) begin errors++; $display("FAIL eff_pulses: got %0d required 40", pulses); end
    checks++;
    if ({cov_count, kept_count, total_count, stop_reason} !== {11'd0, 16'd0, 16'd5, 1'b1}) begin
      errors++; $display("FAIL eff_counts: cov=%0d kept=%0d total=%0d reason=%b required 0/0/5/1", cov_count, kept_count, total_count, stop_reason);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    int n = 0;
    int bad = 0;
    acc_ready = 1'b0;
    start_session(60'h0000_0000_0000_ACE, 2);
    while (!acc_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    held = test_vec;
    for (int i = 0; i < 10; i++) begin
      if ((acc_valid !== 1'b1) || (test_vec !== held) || (inject !== 1'b0)) bad++;
      @(negedge clk);
    end
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles, required 0", bad); end
    checks++;
    #1 acc_ready = 1'b1;
    @(negedge clk);
    if ({acc_valid, total_count} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL bp_release: valid=%b total=%0d required 0/1", acc_valid, total_count);
    end
    checks++;
    @(negedge clk);
    if (total_count !== 16'd2) begin errors++; $display("FAIL bp_gen: total=%0d required 2", total_count); end
    checks++;
    wait_done("bp");
    if ({cov_count, kept_count} !== {11'd8, 16'd2}) begin
      errors++; $display("FAIL bp_final: cov=%0d kept=%0d required 8/2", cov_count, kept_count);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_inject();
    test_full_detect();
    test_useless_limit();
    test_fault_dropping();
    test_efficiency_reject();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rtg_fault_sched
`default_nettype wire
